// File: rtl/div_unit.sv
// div_unit: 32-bit multi-cycle restoring divider (signed/unsigned); define DIV_ZERO_FASTPATH_EN for a 2-cycle divide-by-zero path
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  input  logic        start,
  input  logic        annul,
  output logic [63:0] result,
  output logic        ready
);
`ifdef DIV_ZERO_FASTPATH_EN
  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;
`else
  typedef enum logic [1:0] {FREE, ON, END} state_t;
`endif
  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [31:0] rem_q, quo_q, dvs_q, rem_d, quo_d, rem_f, quo_f, op1_mag, op2_mag;
  logic [32:0] diff;
  logic        neg_q_q, neg_r_q, ready_q;
  logic [63:0] result_q;
  assign result = result_q;
  assign ready  = ready_q;
  // one restoring step: shift the next dividend bit into the remainder, trial-subtract, keep on no borrow
  always_comb begin
    op1_mag = (signed_div && opdata1[31]) ? -opdata1 : opdata1;
    op2_mag = (signed_div && opdata2[31]) ? -opdata2 : opdata2;
    diff    = {rem_q, quo_q[31]} - {1'b0, dvs_q};
    rem_d   = diff[32] ? {rem_q[30:0], quo_q[31]} : diff[31:0];
    quo_d   = {quo_q[30:0], ~diff[32]};
    rem_f   = neg_r_q ? -rem_d : rem_d;
    quo_f   = neg_q_q ? -quo_d : quo_d;
  end
  // control FSM with the iteration registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FREE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        FREE: if (start && !annul) begin
          quo_q   <= op1_mag;
          dvs_q   <= op2_mag;
          rem_q   <= '0;
          cnt_q   <= '0;
          neg_q_q <= signed_div && (opdata1[31] ^ opdata2[31]);
          neg_r_q <= signed_div && opdata1[31];
`ifdef DIV_ZERO_FASTPATH_EN
          state_q <= (opdata2 == 32'd0) ? BYZERO : ON;
`else
          state_q <= ON;
`endif
        end
`ifdef DIV_ZERO_FASTPATH_EN
        BYZERO: if (annul) state_q <= FREE;
        else begin
          state_q  <= END;
          ready_q  <= 1'b1;
          result_q <= '0;
        end
`endif
        ON: if (annul) state_q <= FREE;
        else begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q  <= END;
            ready_q  <= 1'b1;
            result_q <= {rem_f, quo_f};
          end
        end
        default: if (!start) begin
          state_q <= FREE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vector bench for div_unit
module tb_div_unit;
  logic        clk = 1'b0;
  logic        rst, signed_div, start, annul, ready;
  logic [31:0] opdata1, opdata2;
  logic [63:0] result;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  div_unit dut (
    .clk(clk), .rst(rst), .signed_div(signed_div), .opdata1(opdata1), .opdata2(opdata2),
    .start(start), .annul(annul), .result(result), .ready(ready)
  );
  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;
  vec_t vecs[12];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run_div(input string name, input vec_t v);
    int n;
    signed_div = v.sgn;
    opdata1    = v.a;
    opdata2    = v.b;
    start      = 1'b1;
    @(posedge clk); #1;
    n = 1;
    opdata1    = $urandom;
    opdata2    = $urandom;
    signed_div = ~v.sgn;
    while (!ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_latency"}, 64'(n), 64'(v.lat));
    chk({name, "_result"}, result, v.exp);
    annul = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    annul = 1'b0;
    chk({name, "_hold_ready"}, {63'b0, ready}, 64'd1);
    chk({name, "_hold_result"}, result, v.exp);
    start = 1'b0;
    @(posedge clk); #1;
    chk({name, "_drop_ready"}, {63'b0, ready}, 64'd0);
  endtask
  initial begin
    logic seen;
    vec_t v;
    vecs[0]  = '{1'b0, 32'd100,        32'd7,        64'h00000002_0000000E, 33};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'h2,        64'hFFFFFFFF_FFFFFFFD, 33};
    vecs[2]  = '{1'b1, 32'h7,          32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33};
    vecs[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000, 33};
`ifdef DIV_ZERO_FASTPATH_EN
    vecs[4]  = '{1'b0, 32'd5,          32'd0,        64'h0,                 2};
`else
    vecs[4]  = '{1'b0, 32'd5,          32'd0,        64'h00000005_FFFFFFFF, 33};
`endif
    vecs[5]  = '{1'b0, 32'hFFFFFFFF,   32'd1,        64'h00000000_FFFFFFFF, 33};
    vecs[6]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF, 64'h00000000_00000001, 33};
    vecs[7]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, 33};
    vecs[8]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF, 64'h80000000_00000000, 33};
    vecs[9]  = '{1'b0, 32'd9,          32'd3,        64'h00000000_00000003, 33};
    vecs[10] = '{1'b1, 32'h7FFFFFFF,   32'h10,       64'h0000000F_07FFFFFF, 33};
    vecs[11] = '{1'b0, 32'd0,          32'd5,        64'h0,                 33};
    rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; opdata1 = '0; opdata2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", {63'b0, ready}, 64'd0);
    chk("reset_result", result, 64'h0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) run_div($sformatf("vec%0d", i), vecs[i]);
    signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    annul = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    annul = 1'b0;
    chk("annul_ready", {63'b0, ready}, 64'd0);
    chk("annul_result_kept", result, vecs[11].exp);
    @(posedge clk); #1;
    v = '{1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33};
    run_div("after_annul", v);
    seen = 1'b0;
    opdata1 = 32'd50; opdata2 = 32'd5; start = 1'b1; annul = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    start = 1'b0; annul = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen |= ready;
    end
    chk("free_annul_no_ready", {63'b0, seen}, 64'd0);
    chk("free_annul_result", result, 64'h00000000_00000003);
    opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    chk("midrst_ready", {63'b0, ready}, 64'd0);
    chk("midrst_result", result, 64'h0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen |= ready;
    end
    chk("midrst_no_pulse", {63'b0, seen}, 64'd0);
    run_div("after_reset", vecs[0]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have ports clk (input, 1, sole clock; all state changes on rising edge) and rst (input, 1, synchronous active-high reset) listed first.
REQ-002 The block SHALL have port signed_div (input, 1): 1 means the operands are two's-complement, 0 means unsigned.
REQ-003 The block SHALL have port opdata1 (input, 32, dividend).
REQ-004 The block SHALL have port opdata2 (input, 32, divisor).
REQ-005 The block SHALL have port start (input, 1): division request, held high by the requester until ready is seen.
REQ-006 The block SHALL have port annul (input, 1): abort the division in progress (pipeline flush).
REQ-007 The block SHALL have port result (output, 64, registered): [63:32] is the remainder (HI), [31:0] is the quotient (LO).
REQ-008 The block SHALL have port ready (output, 1, registered): result is valid.

Function
REQ-009 The block SHALL implement a four-state FSM: FREE, BYZERO, ON, END.
REQ-010 FREE SHALL transition on start=1 and annul=0, latching signed_div, opdata1 and opdata2 on that edge; start=1 with annul=1 SHALL be ignored.
REQ-011 From FREE, a nonzero divisor SHALL lead to ON with the iteration counter at 0; a zero divisor SHALL lead to BYZERO (macro enabled) or ON (macro disabled).
REQ-012 The ON state SHALL perform one restoring-division step per cycle on 32-bit magnitudes: shift, trial-subtract the divisor magnitude, set the quotient bit when the difference is non-negative.
REQ-013 ON SHALL last exactly 32 cycles and then move to END; ready=1 and result SHALL be valid in the 33rd cycle after the start-sampling edge.
REQ-014 In signed mode, operand magnitudes SHALL be taken first; the quotient SHALL be negated when the operand signs differ, and the remainder SHALL take the sign of the dividend.
REQ-015 0x80000000 / 0xFFFFFFFF in signed mode SHALL yield quotient 0x80000000 and remainder 0, with no trap and no flag.
REQ-016 END SHALL hold ready=1 and result stable while start=1; it SHALL return to FREE on the first cycle start=0, clearing ready on that edge.
REQ-017 annul=1 in ON or BYZERO SHALL force FREE on the next edge with ready=0; result SHALL keep its prior value, and a new start SHALL be accepted in the following cycle.
REQ-018 annul in END or FREE SHALL have no effect.
REQ-019 Operand changes after the start-sampling edge SHALL NOT affect the result.
REQ-020 Back-to-back divisions SHALL require at least one cycle of start=0 between them.

Reset
REQ-021 rst=1 SHALL set state=FREE, counter=0, ready=0, result=64'h0 and all internal datapath registers to 0 on the next rising edge.
REQ-022 Reset SHALL take priority over start and annul; reset mid-operation SHALL abort with no ready pulse.

Configuration
REQ-023 The macro DIV_ZERO_FASTPATH_EN SHALL select divide-by-zero handling.
REQ-024 With DIV_ZERO_FASTPATH_EN defined: divisor 0 SHALL go FREE -> BYZERO -> END, with result=64'h0 and ready=1 in the 2nd cycle after start sampling.
REQ-025 Without DIV_ZERO_FASTPATH_EN: divisor 0 SHALL run the normal 32-cycle ON path and return the algorithmic result.
REQ-026 Without the macro, unsigned x/0 SHALL yield quotient 0xFFFFFFFF and remainder x; the BYZERO state SHALL be absent from the build.

Verification
REQ-027 Unsigned 100/7: start at cycle 0 -> ready=1 at cycle 33 with result={32'd2, 32'd14}; ready held until start drops.
REQ-028 Signed -7/2 (0xFFFFFFF9/0x2) -> result={0xFFFFFFFF, 0xFFFFFFFD}; signed 7/-2 -> result={0x1, 0xFFFFFFFD}.
REQ-029 Signed 0x80000000/0xFFFFFFFF -> result={0x0, 0x80000000} at cycle 33.
REQ-030 Divide by zero, 5/0 unsigned:
- Macro enabled -> ready at cycle 2, result=0.
- Macro disabled -> ready at cycle 33, result={0x5, 0xFFFFFFFF}.
REQ-031 Annul at cycle 10 of a division -> ready stays 0, FSM in FREE at cycle 11; new start 9/3 at cycle 12 -> result={0, 3} at cycle 45.
REQ-032 rst asserted at cycle 20 of a division -> result=0, ready=0 next cycle; later division completes normally.
